// File: rtl/stream_multicast_fork.sv
// Ready/valid fork: one registered input beat is replicated to CHANNELS outputs,
// gated by a per-beat destination mask, and retired once every selected output took it.
module stream_multicast_fork #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [CHANNELS-1:0]            in_mask,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]            out_valid,
  input  logic [CHANNELS-1:0]            out_ready
);

  logic [DATA_WIDTH-1:0] buf_data_r;
  logic [CHANNELS-1:0]   pending_r;
  logic [CHANNELS-1:0]   take_s;
  logic [CHANNELS-1:0]   remain_s;
  logic                  drain_s;
  logic                  buf_full_s;
  logic                  accept_s;

  // Handshake decode: the buffer frees up in the same cycle its last pending channel takes.
  always_comb begin
    take_s     = pending_r & out_ready;
    remain_s   = pending_r & ~take_s;
    drain_s    = (remain_s == {CHANNELS{1'b0}});
    buf_full_s = |pending_r;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = !buf_full_s || drain_s;
    end
    accept_s = in_valid & in_ready;
  end

  // Beat buffer and per-channel pending mask; a zero mask loads nothing visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_r <= {DATA_WIDTH{1'b0}};
      pending_r  <= {CHANNELS{1'b0}};
    end else if (accept_s) begin
      buf_data_r <= in_data;
      pending_r  <= in_mask;
    end else begin
      buf_data_r <= buf_data_r;
      pending_r  <= remain_s;
    end
  end

  // Outputs come straight from registers, so they stay stable until taken.
  always_comb begin
    out_valid = pending_r;
    out_data  = {(CHANNELS*DATA_WIDTH){1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = buf_data_r;
    end
  end

endmodule

// File: tb/tb_stream_multicast_fork.sv
// Scoreboard bench for stream_multicast_fork: per-channel expected-beat queues filled
// on input handshakes, drained by an independent output monitor.
module tb_stream_multicast_fork;

  localparam int DW = 8;
  localparam int CH = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic [CH-1:0]     in_mask = '0;
  logic              in_valid = 1'b1;
  logic              in_ready;
  logic [CH*DW-1:0]  out_data;
  logic [CH-1:0]     out_valid;
  logic [CH-1:0]     out_ready = '0;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel owns a FIFO of beats it still has to deliver.
  logic [DW-1:0] exp_q [CH][$];

  stream_multicast_fork #(.DATA_WIDTH(DW), .CHANNELS(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Output monitor: compares every presented beat with the head of its channel queue.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
    end else begin
      for (int i = 0; i < CH; i++) begin
        check($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0) begin
          check($sformatf("out_data%0d", i), 32'(out_data[i*DW +: DW]), 32'(exp_q[i][0]));
          if (out_ready[i]) void'(exp_q[i].pop_front());
        end
      end
    end
  end

  // One stimulus cycle: drive after the edge, predict in_ready, record accepted beats.
  task automatic cycle(input logic v, input logic [CH-1:0] m, input logic [DW-1:0] d,
                       input logic [CH-1:0] r);
    logic exp_ready;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_mask   = m;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    // The buffer is free when every channel still owing a beat takes it now.
    exp_ready = 1'b1;
    for (int i = 0; i < CH; i++)
      if (exp_q[i].size() != 0 && !r[i]) exp_ready = 1'b0;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    #1;
    if (v && exp_ready)
      for (int i = 0; i < CH; i++)
        if (m[i]) exp_q[i].push_back(d);
  endtask

  task automatic reset_pulse(input int n);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mask  = '1;
    for (int i = 0; i < CH; i++) exp_q[i].delete();
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_ready", 32'(in_ready), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_pulse(3);

    // Full-rate broadcast.
    cycle(1'b1, 3'b111, 8'h11, 3'b111);
    cycle(1'b1, 3'b111, 8'h22, 3'b111);
    cycle(1'b1, 3'b111, 8'h33, 3'b111);
    cycle(1'b0, 3'b000, 8'h00, 3'b111);

    // Staggered acceptance: ch0, then ch2, nobody, then ch1.
    cycle(1'b1, 3'b111, 8'hA5, 3'b111);
    cycle(1'b1, 3'b111, 8'hEE, 3'b001);
    check("stagger_valid_a", 32'(out_valid), 32'b111);
    cycle(1'b1, 3'b111, 8'hEE, 3'b100);
    check("stagger_valid_b", 32'(out_valid), 32'b110);
    cycle(1'b1, 3'b111, 8'hEE, 3'b000);
    check("stagger_valid_c", 32'(out_valid), 32'b010);
    cycle(1'b0, 3'b000, 8'h00, 3'b010);
    check("stagger_valid_d", 32'(out_valid), 32'b010);
    cycle(1'b0, 3'b000, 8'h00, 3'b111);
    check("stagger_valid_e", 32'(out_valid), 32'b000);

    // Multicast with a zero-mask beat in between.
    cycle(1'b1, 3'b101, 8'h5A, 3'b111);
    cycle(1'b1, 3'b000, 8'hFF, 3'b111);
    cycle(1'b1, 3'b010, 8'h3C, 3'b111);
    cycle(1'b0, 3'b000, 8'h00, 3'b111);

    // Drain plus refill in the same cycle.
    cycle(1'b1, 3'b010, 8'h99, 3'b000);
    cycle(1'b1, 3'b001, 8'h77, 3'b010);
    cycle(1'b0, 3'b000, 8'h00, 3'b000);
    check("refill_valid", 32'(out_valid), 32'b001);
    cycle(1'b0, 3'b000, 8'h00, 3'b001);

    // Reset mid-operation drops the pending beat.
    cycle(1'b1, 3'b001, 8'hC3, 3'b000);
    cycle(1'b0, 3'b000, 8'h00, 3'b000);
    reset_pulse(1);
    cycle(1'b0, 3'b000, 8'h00, 3'b111);

    // Randomized traffic with random sink back-pressure.
    for (int k = 0; k < 1500; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
            3'($urandom_range(0, 7) | (($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000)));
      if (k == 700) reset_pulse(2);
    end

    // Drain and confirm every recorded beat was delivered exactly once.
    repeat (4) cycle(1'b0, 3'b000, 8'h00, 3'b111);
    for (int i = 0; i < CH; i++)
      check($sformatf("leftover%0d", i), 32'(exp_q[i].size()), 32'd0);
    check("final_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_multicast_fork.md
# stream_multicast_fork

Parametrised ready/valid fork that replicates one input stream onto `CHANNELS` output streams, with a per-beat destination mask. Each output consumes independently. The input beat is retired only when every selected output has taken it. One register stage sits between input and outputs, so a slow consumer never drops data. The block replaces hand-wired fan-out of a forward/reverse interface pair to several sinks.

## Interface
- `DATA_WIDTH`, default 8: payload width in bits, ≥1.
- `CHANNELS`, default 2: number of output streams, 1..32.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input `DATA_WIDTH`: input payload.
- `in_mask` input `CHANNELS`: destination channels for this beat; bit i selects output i.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block accepts the input beat this cycle.
- `out_data` output `CHANNELS*DATA_WIDTH`: per-channel payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_valid` output `CHANNELS`: per-channel beat present.
- `out_ready` input `CHANNELS`: per-channel sink acceptance.

## Operation
- State registers:
  - `buf_data` (`DATA_WIDTH`).
  - `pending` (`CHANNELS`): channels not yet served.
  - `buf_full` = |pending.
- Outputs:
  - `out_valid[i]` = `pending[i]`.
  - every `out_data` slice = `buf_data`.
- `take[i]` = `out_valid[i] & out_ready[i]`.
- `drain` = (`pending & ~take`) == 0, i.e. all remaining channels take this cycle.
- `in_ready` = `!buf_full | drain`. It is forced 0 while `rst` is high.
- Input handshake (`in_valid & in_ready`):
  - `buf_data` ← `in_data`.
  - `pending` ← `in_mask`.
- Otherwise: `pending` ← `pending & ~take`. `buf_data` holds.
- Zero mask: a beat with `in_mask` == 0 is consumed in its handshake cycle, produces no output, and leaves `pending` = 0.
- Single-channel case: `CHANNELS` = 1 degenerates to a one-entry pipeline register with mask gating.
- Ordering: outputs see beats in input order. A channel never sees beat n+1 before every selected channel has taken beat n.
- Stable outputs: `out_valid[i]`, once high, stays high with `out_data` stable until `take[i]`. This holds regardless of other channels or `in_valid`.
- Handshake rules:
  - `in_data`, `in_mask` and `in_valid` are sampled only on a handshake.
  - `out_ready` may toggle freely.
  - The block does not require `out_ready` to wait for `out_valid`.

## Timing
- Reset (async assert, sync release):
  - `pending` = 0 and `buf_data` = 0.
  - `out_valid` = 0 and `out_data` = 0.
  - `in_ready` = 0 during reset, 1 in the first cycle after release.
- Latency: input handshake at edge k → `out_valid` high for selected channels in cycle k+1.
- Throughput:
  - One beat per cycle when every selected channel's `out_ready` is high.
  - With a stalled channel, throughput is 0 until that channel takes.
- Simultaneous events: drain and new input in the same cycle load the new beat with no bubble cycle.
- Partial take: channels that took are cleared from `pending` and do not see the beat again; channels still pending keep `out_valid` high.
- Combinational paths:
  - `out_ready` → `in_ready` (via `drain`).
  - `rst` → `in_ready`.
  - No path from `in_valid` or `in_data` to any output.
- Reset mid-operation: the pending beat is discarded with no output handshake completing. After release the block behaves as post-reset.

## Test plan
- Reset then idle: `rst` pulse with `in_valid`=1 during reset → `in_ready`=0 and `out_valid`=0 throughout reset. `in_ready`=1 on the first cycle after release.
- Full-rate broadcast, `CHANNELS`=3, all `out_ready`=1: beats 0x11, 0x22, 0x33 with mask 3'b111 on consecutive cycles → each channel shows 0x11/0x22/0x33 at cycles k+1..k+3, and `in_ready` stays 1.
- Staggered acceptance, mask 3'b111, data 0xA5:
  - ch0 takes at cycle 1, ch2 at cycle 2, ch1 at cycle 4.
  - Required: `out_valid` = 3'b110 after cycle 1, then 3'b010, then 0.
  - `in_ready`=0 on cycles 1..3 and 1 on cycle 4.
  - Each channel sees 0xA5 exactly once.
- Multicast and zero mask: mask 3'b101 data 0x5A, then mask 3'b000 data 0xFF, then mask 3'b010 data 0x3C → ch0 and ch2 see 0x5A, no channel sees 0xFF, ch1 sees 0x3C. The 0xFF beat is accepted in one cycle.
- Drain plus refill: beat pending on ch1 only. In one cycle ch1 takes while `in_valid`=1 with mask 3'b001, data 0x77 → `in_ready`=1 that cycle, and ch0 shows 0x77 on the next cycle with no bubble.
- Reset mid-operation: beat 0xC3 pending on ch0 with `out_ready`=0. Assert `rst` for one cycle → `out_valid`=0 immediately and 0xC3 is never delivered. Post-release behaviour matches the reset scenario.
